lsharp_reg_sequencer: RTL and testbench

//  Sequences every access to LSharp_Reg_File and shares its single 8/16-bit read/write ports between
//  two requesters: the fetch unit (PC read + post-increment) and the execute unit (register micro-ops).
//  It drives the file's one-hot read/write strobes and data buses, and runs multi-cycle ops (SWAP8) itself.

---
 rtl/lsharp_reg_sequencer_if.sv | 37 +++
 rtl/lsharp_reg_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_lsharp_reg_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsharp_reg_sequencer_if.sv
// Request/response and register-file signals shared by the LSharp register-access sequencer.
// Command handshake: a command transfers on a clock edge where cmd_valid and cmd_ready are both 1; the requester holds cmd_* stable while cmd_valid=1 and cmd_ready=0.
interface lsharp_reg_sequencer_if;
    logic        fetch_req;
    logic        fetch_ack;
    logic [15:0] pc;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src;
    logic [15:0] cmd_imm;
    logic        done;
    logic        illegal;
    logic        busy;
    logic [7:0]  read8;
    logic [7:0]  write8;
    logic [7:0]  read16;
    logic [7:0]  write16;
    logic [7:0]  bus8;
    logic [15:0] bus16;
    logic [7:0]  rf_bus8;
    logic [15:0] rf_bus16;
    logic [2:0]  state_dbg;

    modport master (
        input  fetch_req, cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_bus8, rf_bus16,
        output fetch_ack, pc, cmd_ready, done, illegal, busy,
               read8, write8, read16, write16, bus8, bus16, state_dbg
    );

    modport slave (
        output fetch_req, cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_imm, rf_bus8, rf_bus16,
        input  fetch_ack, pc, cmd_ready, done, illegal, busy,
               read8, write8, read16, write16, bus8, bus16, state_dbg
    );
endinterface

// File: rtl/lsharp_reg_sequencer.sv
// Shares the LSharp register file's single 8/16-bit ports between PC fetch and execute micro-ops,
// arbitrating round-robin in IDLE and sequencing the three-cycle SWAP8 internally.
module lsharp_reg_sequencer #(
    parameter int unsigned PC_INDEX  = 5,
    parameter logic [15:0] FETCH_INC = 16'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    lsharp_reg_sequencer_if.master seq
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EXEC  = 3'd1,
        SWAP1 = 3'd2,
        SWAP2 = 3'd3,
        SWAP3 = 3'd4
    } state_t;

    localparam logic [2:0] OP_MOV8  = 3'd1;
    localparam logic [2:0] OP_LDI8  = 3'd2;
    localparam logic [2:0] OP_MOV16 = 3'd3;
    localparam logic [2:0] OP_LDI16 = 3'd4;
    localparam logic [2:0] OP_INC16 = 3'd5;
    localparam logic [2:0] OP_DEC16 = 3'd6;
    localparam logic [2:0] OP_SWAP8 = 3'd7;

    localparam logic [7:0] PC_STROBE = 8'(1 << PC_INDEX);

    state_t      state;
    logic        last_fetch;
    logic [7:0]  temp;
    logic [2:0]  op;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [15:0] imm;

    logic active;
    logic fetch_win;
    logic cmd_win;
    logic illegal16;

    function automatic logic [7:0] onehot(input logic [2:0] code);
        onehot = 8'd1 << code;
    endfunction

    // Reset gates the strobes in its own cycle so an aborted SWAP commits nothing further.
    assign active    = enable & ~reset;
    assign fetch_win = active && (state == IDLE) && seq.fetch_req && (!seq.cmd_valid || !last_fetch);
    assign cmd_win   = active && (state == IDLE) && seq.cmd_valid && !fetch_win;

    // Only codes 0-5 exist in the 16-bit space; check just the operands the op actually uses.
    assign illegal16 = ((op == OP_MOV16) && ((src[2:1] == 2'b11) || (dst[2:1] == 2'b11))) ||
                       (((op == OP_LDI16) || (op == OP_INC16) || (op == OP_DEC16)) &&
                        (dst[2:1] == 2'b11));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_fetch <= 1'b0;
            temp       <= 8'h00;
            op         <= 3'd0;
            dst        <= 3'd0;
            src        <= 3'd0;
            imm        <= 16'h0000;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    if (fetch_win) begin
                        last_fetch <= 1'b1;
                    end else if (cmd_win) begin
                        last_fetch <= 1'b0;
                        op         <= seq.cmd_op;
                        dst        <= seq.cmd_dst;
                        src        <= seq.cmd_src;
                        imm        <= seq.cmd_imm;
                        state      <= (seq.cmd_op == OP_SWAP8) ? SWAP1 : EXEC;
                    end
                end
                EXEC:  state <= IDLE;
                SWAP1: begin
                    temp  <= seq.rf_bus8;
                    state <= SWAP2;
                end
                SWAP2: state <= SWAP3;
                SWAP3: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read strobes are kept apart from the data path, which consumes the read data they select.
    always_comb begin
        seq.read8  = 8'h00;
        seq.read16 = 8'h00;
        if (fetch_win) begin
            seq.read16 = PC_STROBE;
        end else if (active) begin
            case (state)
                EXEC: begin
                    case (op)
                        OP_MOV8:  seq.read8 = onehot(src);
                        OP_MOV16: if (!illegal16) seq.read16 = onehot(src);
                        OP_INC16,
                        OP_DEC16: if (!illegal16) seq.read16 = onehot(dst);
                        default: ;
                    endcase
                end
                SWAP1: seq.read8 = onehot(dst);
                SWAP2: seq.read8 = onehot(src);
                default: ;
            endcase
        end
    end

    always_comb begin
        seq.write8    = 8'h00;
        seq.write16   = 8'h00;
        seq.bus8      = 8'h00;
        seq.bus16     = 16'h0000;
        seq.pc        = 16'h0000;
        seq.fetch_ack = 1'b0;
        seq.done      = 1'b0;
        seq.illegal   = 1'b0;
        if (fetch_win) begin
            seq.write16   = PC_STROBE;
            seq.bus16     = seq.rf_bus16 + FETCH_INC;
            seq.pc        = seq.rf_bus16;
            seq.fetch_ack = 1'b1;
        end else if (active) begin
            case (state)
                EXEC: begin
                    seq.done    = 1'b1;
                    seq.illegal = illegal16;
                    case (op)
                        OP_MOV8: begin
                            seq.write8 = onehot(dst);
                            seq.bus8   = seq.rf_bus8;
                        end
                        OP_LDI8: begin
                            seq.write8 = onehot(dst);
                            seq.bus8   = imm[7:0];
                        end
                        OP_MOV16: if (!illegal16) begin
                            seq.write16 = onehot(dst);
                            seq.bus16   = seq.rf_bus16;
                        end
                        OP_LDI16: if (!illegal16) begin
                            seq.write16 = onehot(dst);
                            seq.bus16   = imm;
                        end
                        OP_INC16: if (!illegal16) begin
                            seq.write16 = onehot(dst);
                            seq.bus16   = seq.rf_bus16 + 16'd1;
                        end
                        OP_DEC16: if (!illegal16) begin
                            seq.write16 = onehot(dst);
                            seq.bus16   = seq.rf_bus16 - 16'd1;
                        end
                        default: ;
                    endcase
                end
                SWAP2: begin
                    seq.write8 = onehot(dst);
                    seq.bus8   = seq.rf_bus8;
                end
                SWAP3: begin
                    seq.write8 = onehot(src);
                    seq.bus8   = temp;
                    seq.done   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign seq.cmd_ready = cmd_win;
    assign seq.busy      = (state != IDLE);
    assign seq.state_dbg = state;
endmodule

// File: tb/tb_lsharp_reg_sequencer.sv
// Bench for lsharp_reg_sequencer: a behavioural register file answers the DUT strobes while a
// transaction-level model predicts handshakes, PC values and register contents.
module tb_lsharp_reg_sequencer;
    localparam logic [2:0]  OP_NOP    = 3'd0;
    localparam logic [2:0]  OP_LDI8   = 3'd2;
    localparam logic [2:0]  OP_MOV16  = 3'd3;
    localparam logic [2:0]  OP_LDI16  = 3'd4;
    localparam logic [2:0]  OP_INC16  = 3'd5;
    localparam logic [2:0]  OP_DEC16  = 3'd6;
    localparam logic [2:0]  OP_SWAP8  = 3'd7;
    localparam logic [15:0] FETCH_INC = 16'd1;

    logic clk = 1'b0;
    logic reset;
    logic enable;

    lsharp_reg_sequencer_if ifc ();

    lsharp_reg_sequencer #(.PC_INDEX(5), .FETCH_INC(FETCH_INC)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .seq    (ifc)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Environment register file: 8-bit codes W Z B C D E H L, 16-bit codes WZ BC DE HL SP PC.
    logic [7:0]  env8 [8] = '{default: 8'h00};
    logic [15:0] env_sp   = 16'h0000;
    logic [15:0] env_pc   = 16'h0000;

    always_comb begin
        ifc.rf_bus8 = 8'h00;
        for (int i = 0; i < 8; i++)
            if (ifc.read8[i]) ifc.rf_bus8 = env8[i];
    end

    always_comb begin
        ifc.rf_bus16 = 16'h0000;
        for (int i = 0; i < 6; i++)
            if (ifc.read16[i])
                ifc.rf_bus16 = (i < 4) ? {env8[2*i], env8[2*i+1]} : ((i == 4) ? env_sp : env_pc);
    end

    always @(posedge clk) begin
        for (int i = 0; i < 8; i++)
            if (ifc.write8[i]) env8[i] <= ifc.bus8;
        for (int i = 0; i < 6; i++)
            if (ifc.write16[i]) begin
                if (i < 4) begin
                    env8[2*i]   <= ifc.bus16[15:8];
                    env8[2*i+1] <= ifc.bus16[7:0];
                end else if (i == 4) begin
                    env_sp <= ifc.bus16;
                end else begin
                    env_pc <= ifc.bus16;
                end
            end
    end

    // Reference model state.
    logic [7:0]  ref8 [8] = '{default: 8'h00};
    logic [15:0] ref_sp   = 16'h0000;
    logic [15:0] ref_pc   = 16'h0000;
    int          busy_left  = 0;
    logic        fetch_last = 1'b0;
    logic        accepted   = 1'b0;
    int          n_ack      = 0;
    logic        saw_illegal = 1'b0;
    logic [2:0]  cur_op, cur_dst, cur_src;
    logic [15:0] cur_imm;

    function automatic logic [15:0] ref_get16(input logic [2:0] c);
        if (c < 3'd4) return {ref8[{c[1:0], 1'b0}], ref8[{c[1:0], 1'b1}]};
        else if (c == 3'd4) return ref_sp;
        else return ref_pc;
    endfunction

    task automatic ref_set16(input logic [2:0] c, input logic [15:0] v);
        if (c < 3'd4) begin
            ref8[{c[1:0], 1'b0}] = v[15:8];
            ref8[{c[1:0], 1'b1}] = v[7:0];
        end else if (c == 3'd4) begin
            ref_sp = v;
        end else begin
            ref_pc = v;
        end
    endtask

    function automatic logic exp_illegal(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s);
        return (op >= OP_MOV16 && op <= OP_DEC16 && d >= 3'd6) || (op == OP_MOV16 && s >= 3'd6);
    endfunction

    task automatic ref_apply(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                             input logic [15:0] imm);
        logic [7:0] t;
        case (op)
            3'd1: ref8[d] = ref8[s];
            3'd2: ref8[d] = imm[7:0];
            3'd3: ref_set16(d, ref_get16(s));
            3'd4: ref_set16(d, imm);
            3'd5: ref_set16(d, ref_get16(d) + 16'd1);
            3'd6: ref_set16(d, ref_get16(d) - 16'd1);
            3'd7: begin
                t       = ref8[d];
                ref8[d] = ref8[s];
                ref8[s] = t;
            end
            default: ;
        endcase
    endtask

    function automatic logic [63:0] env_pack();
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[55:0], env8[i]};
        return v;
    endfunction

    function automatic logic [63:0] ref_pack();
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[55:0], ref8[i]};
        return v;
    endfunction

    // Evaluated once per cycle at the falling edge, after inputs settled.
    task automatic model_step();
        logic e_ack, e_ready, e_done, e_ill, viol;
        accepted = 1'b0;
        e_ack = 1'b0; e_ready = 1'b0; e_done = 1'b0; e_ill = 1'b0;
        viol = !$onehot0(ifc.read8) || !$onehot0(ifc.write8) || !$onehot0(ifc.read16) ||
               !$onehot0(ifc.write16) || ((|ifc.write8) && (|ifc.write16));
        check("strobe_rules", 64'(viol), 64'd0);
        if (busy_left == 0) begin
            check("regs8", env_pack(), ref_pack());
            check("reg_sp", 64'(env_sp), 64'(ref_sp));
            check("reg_pc", 64'(env_pc), 64'(ref_pc));
        end
        if (reset || !enable) begin
            check("quiet_hs", 64'({ifc.fetch_ack, ifc.cmd_ready, ifc.done, ifc.illegal}), 64'd0);
            check("quiet_strobes", 64'({ifc.read8, ifc.write8, ifc.read16, ifc.write16}), 64'd0);
            if (reset) begin
                if (busy_left == 1 && cur_op == OP_SWAP8) ref8[cur_dst] = ref8[cur_src];
                busy_left  = 0;
                fetch_last = 1'b0;
            end else begin
                check("busy_frozen", 64'(ifc.busy), 64'(busy_left != 0));
            end
        end else begin
            check("busy", 64'(ifc.busy), 64'(busy_left != 0));
            if (busy_left > 0) begin
                e_done = (busy_left == 1);
                e_ill  = e_done && exp_illegal(cur_op, cur_dst, cur_src);
            end else begin
                e_ack   = ifc.fetch_req && (!ifc.cmd_valid || !fetch_last);
                e_ready = ifc.cmd_valid && !e_ack;
            end
            check("handshake", 64'({ifc.fetch_ack, ifc.cmd_ready, ifc.done, ifc.illegal}),
                  64'({e_ack, e_ready, e_done, e_ill}));
            if (e_ill) saw_illegal = 1'b1;
            if (busy_left > 0) begin
                if (e_done && !e_ill) ref_apply(cur_op, cur_dst, cur_src, cur_imm);
                busy_left--;
            end else if (e_ack) begin
                check("fetch_pc", 64'(ifc.pc), 64'(ref_pc));
                ref_pc     = ref_pc + FETCH_INC;
                fetch_last = 1'b1;
                n_ack++;
            end else if (e_ready) begin
                cur_op     = ifc.cmd_op;
                cur_dst    = ifc.cmd_dst;
                cur_src    = ifc.cmd_src;
                cur_imm    = ifc.cmd_imm;
                busy_left  = (ifc.cmd_op == OP_SWAP8) ? 3 : 1;
                fetch_last = 1'b0;
                accepted   = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                            input logic [15:0] imm, output int acks);
        int a0 = n_ack;
        ifc.cmd_valid = 1'b1;
        ifc.cmd_op    = op;
        ifc.cmd_dst   = d;
        ifc.cmd_src   = s;
        ifc.cmd_imm   = imm;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (accepted) break;
        end
        if (!accepted) check("accept_timeout", 64'd1, 64'd0);
        ifc.cmd_valid = 1'b0;
        acks = n_ack - a0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (busy_left == 0) break;
            cycle();
        end
        if (busy_left != 0) check("idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [2:0] d, input logic [2:0] s,
                           input logic [15:0] imm);
        int a;
        send_cmd(op, d, s, imm, a);
        wait_idle();
    endtask

    initial begin
        int a1, a2, a0;
        reset = 1'b1;
        enable = 1'b1;
        ifc.fetch_req = 1'b0;
        ifc.cmd_valid = 1'b0;
        ifc.cmd_op = 3'd0; ifc.cmd_dst = 3'd0; ifc.cmd_src = 3'd0; ifc.cmd_imm = 16'h0000;
        cycle();
        cycle();
        reset = 1'b0;

        // Contention from reset: fetch first, then the command, then fetch again.
        ifc.fetch_req = 1'b1;
        send_cmd(OP_LDI16, 3'd1, 3'd0, 16'hBEEF, a1);
        send_cmd(OP_NOP, 3'd0, 3'd0, 16'h0000, a2);
        wait_idle();
        ifc.fetch_req = 1'b0;
        cycle();
        check("t2_fetch_first", 64'(a1), 64'd1);
        check("t2_fetch_again", 64'(a2), 64'd1);
        check("t2_bc", 64'({env8[2], env8[3]}), 64'h0000_BEEF);

        // Back-to-back fetches from PC=0100.
        run_cmd(OP_LDI16, 3'd5, 3'd0, 16'h0100);
        a0 = n_ack;
        ifc.fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        ifc.fetch_req = 1'b0;
        check("t1_acks", 64'(n_ack - a0), 64'd3);
        check("t1_pc", 64'(env_pc), 64'h0103);

        // SWAP8 B<->C with the other registers populated.
        run_cmd(OP_LDI16, 3'd0, 3'd0, 16'h1357);
        run_cmd(OP_LDI16, 3'd2, 3'd0, 16'h2468);
        run_cmd(OP_LDI16, 3'd3, 3'd0, 16'h9ACE);
        run_cmd(OP_LDI8, 3'd2, 3'd0, 16'h0012);
        run_cmd(OP_LDI8, 3'd3, 3'd0, 16'h0034);
        run_cmd(OP_SWAP8, 3'd2, 3'd3, 16'h0000);
        cycle();
        check("t3_b", 64'(env8[2]), 64'h34);
        check("t3_c", 64'(env8[3]), 64'h12);
        run_cmd(OP_SWAP8, 3'd6, 3'd6, 16'h0000);

        // 16-bit wrap and MOV16 into SP.
        run_cmd(OP_LDI16, 3'd3, 3'd0, 16'hFFFF);
        run_cmd(OP_INC16, 3'd3, 3'd0, 16'h0000);
        cycle();
        check("t4_hl_inc", 64'({env8[6], env8[7]}), 64'h0000);
        run_cmd(OP_DEC16, 3'd3, 3'd0, 16'h0000);
        run_cmd(OP_MOV16, 3'd4, 3'd3, 16'h0000);
        cycle();
        check("t4_hl_dec", 64'({env8[6], env8[7]}), 64'hFFFF);
        check("t4_sp", 64'(env_sp), 64'hFFFF);

        // Illegal 16-bit destination.
        saw_illegal = 1'b0;
        run_cmd(OP_MOV16, 3'd6, 3'd1, 16'h0000);
        cycle();
        check("t5_illegal", 64'(saw_illegal), 64'd1);

        // Reset in SWAP2 (nothing committed) and in SWAP3 (dst already written).
        run_cmd(OP_LDI8, 3'd4, 3'd0, 16'h00AA);
        run_cmd(OP_LDI8, 3'd5, 3'd0, 16'h0055);
        send_cmd(OP_SWAP8, 3'd4, 3'd5, 16'h0000, a1);
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("t6_d_kept", 64'(env8[4]), 64'hAA);
        send_cmd(OP_SWAP8, 3'd4, 3'd5, 16'h0000, a1);
        cycle();
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        cycle();
        check("t6_d_partial", 64'(env8[4]), 64'h55);
        check("t6_e_kept", 64'(env8[5]), 64'h55);

        // Freeze mid-SWAP, then resume.
        run_cmd(OP_LDI8, 3'd0, 3'd0, 16'h00C3);
        send_cmd(OP_SWAP8, 3'd0, 3'd4, 16'h0000, a1);
        cycle();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        enable = 1'b1;
        wait_idle();
        cycle();
        check("t6_w_swapped", 64'(env8[0]), 64'h55);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            if (!ifc.cmd_valid && $urandom_range(0, 1) == 0) begin
                ifc.cmd_valid = 1'b1;
                ifc.cmd_op    = 3'($urandom_range(0, 7));
                ifc.cmd_dst   = 3'($urandom_range(0, 7));
                ifc.cmd_src   = (ifc.cmd_op >= OP_LDI16 && ifc.cmd_op <= OP_DEC16) ?
                                3'($urandom_range(0, 5)) : 3'($urandom_range(0, 7));
                ifc.cmd_imm   = 16'($urandom);
            end
            ifc.fetch_req = ($urandom_range(0, 2) == 0);
            enable        = ($urandom_range(0, 9) != 0);
            cycle();
            if (accepted) ifc.cmd_valid = 1'b0;
        end
        ifc.cmd_valid = 1'b0;
        ifc.fetch_req = 1'b0;
        enable = 1'b1;
        wait_idle();
        cycle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
